// File: rtl/data_ram_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores, a registered
// one-cycle response, and a clear FSM that writes CLR_VAL to every word after reset or on request.
module data_ram_sized #(
    parameter int          ADDR_W  = 7,
    parameter logic [31:0] CLR_VAL = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        init_done
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int WORDS = 1 << IDX_W;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              err_q, err_d;
    logic              init_done_q, init_done_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem [WORDS];

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;
    logic              acc_err;
    logic [3:0]        store_be;
    logic [31:0]       store_data;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;

    assign word_idx = addr[ADDR_W-1:2];
    assign rd_word  = mem[word_idx];
    assign rd_half  = addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        rd_byte    = rd_word[7:0];
        load_data  = rd_word;
        acc_err    = 1'b0;
        store_be   = 4'b0000;
        store_data = wdata;
        case (addr[1:0])
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        case (size)
            2'b00: begin
                load_data  = is_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                store_be   = 4'b0001 << addr[1:0];
                store_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                acc_err    = addr[0];
                load_data  = is_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                store_be   = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                acc_err  = (addr[1:0] != 2'b00);
                store_be = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
        // Anything above the decoded byte range is rejected rather than aliased.
        if ((addr >> ADDR_W) != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        init_done_d  = init_done_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_we       = 1'b0;
        mem_idx      = word_idx;
        mem_wdata    = store_data;
        mem_be       = 4'b0000;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q;
                mem_wdata = CLR_VAL;
                mem_be    = 4'b1111;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(WORDS - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d     = ST_CLEAR;
                    clr_cnt_d   = '0;
                    init_done_d = 1'b0;
                end else if (req) begin
                    resp_valid_d = 1'b1;
                    err_d        = acc_err;
                    rdata_d      = (acc_err || we) ? 32'd0 : load_data;
                    if (we && !acc_err) begin
                        mem_we = 1'b1;
                        mem_be = store_be;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            init_done_q  <= init_done_d;
        end
    end

    // Array has no reset; the clear FSM is what initialises it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign ready      = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign init_done  = init_done_q;

endmodule
